rom_arbiter: RTL and testbench

- Shares the single combinational-read instruction ROM between two requesters.
  - Port 0: the IF stage.
  - Port 1: a debug/loader read port.
- Sequences each access through a 3-state FSM and returns registered read data with a one-cycle ack pulse.
- Sits between the IF/debug logic and the ROM; it is the only driver of ROM ce/addr.

---
 rtl/rom_arbiter_pkg.sv | 8 +
 rtl/rom_arbiter_if.sv | 27 ++
 rtl/rom_arb_pick.sv | 16 +
 rtl/rom_arbiter.sv | 81 ++++++++
 tb/tb_rom_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared FSM states, port ids and chip-enable levels for the ROM arbiter
package rom_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RSP = 2'd2} state_e;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam logic CE_EN = 1'b1;
  localparam logic CE_DIS = 1'b0;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: IF, debug and ROM-side signals of the arbiter; master drives requests and ROM data
interface rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic if_flush;
  logic if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic busy;
  modport master (
    output if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    input if_ack, if_rdata, dbg_ack, dbg_rdata, rom_ce, rom_addr, busy
  );
  modport slave (
    input if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    output if_ack, if_rdata, dbg_ack, dbg_rdata, rom_ce, rom_addr, busy
  );
endinterface

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational two-way winner select; a flushing IF port is not eligible
module rom_arb_pick import rom_arbiter_pkg::*; #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic if_req_i,
  input  logic dbg_req_i,
  input  logic if_flush_i,
  input  logic last_gnt_i,
  output logic valid_o,
  output logic gnt_o
);
  logic if_ok;
  assign if_ok = if_req_i & ~if_flush_i;
  assign valid_o = if_ok | dbg_req_i;
  assign gnt_o = (if_ok & dbg_req_i) ? (FIXED_PRIO ? PORT_IF : ~last_gnt_i) : (if_ok ? PORT_IF : PORT_DBG);
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between IF and debug ports; ROM_ARB_PERF_EN adds conflict_cnt
module rom_arbiter import rom_arbiter_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic clk,
  input logic rst,
  rom_arbiter_if.slave bus
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [31:0] conflict_cnt
`endif
);
  state_e state_q;
  logic gnt_q, last_gnt_q, rom_ce_q, if_ack_q, dbg_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] if_rdata_q, dbg_rdata_q;
  logic pick_valid, pick_gnt;
  rom_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .if_req_i(bus.if_req),
    .dbg_req_i(bus.dbg_req),
    .if_flush_i(bus.if_flush),
    .last_gnt_i(last_gnt_q),
    .valid_o(pick_valid),
    .gnt_o(pick_gnt)
  );
  assign bus.rom_ce = rom_ce_q;
  assign bus.rom_addr = addr_q;
  assign bus.if_ack = if_ack_q & ~bus.if_flush;
  assign bus.dbg_ack = dbg_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.busy = state_q != IDLE;
  // addr_q only holds a value during ACC so it doubles as the ROM address output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= PORT_IF;
      last_gnt_q <= PORT_DBG;
      rom_ce_q <= CE_DIS;
      addr_q <= '0;
      if_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      if_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_valid) begin
          state_q <= ACC;
          gnt_q <= pick_gnt;
          last_gnt_q <= pick_gnt;
          rom_ce_q <= CE_EN;
          addr_q <= pick_gnt == PORT_IF ? bus.if_addr : bus.dbg_addr;
        end
        ACC: begin
          state_q <= RSP;
          rom_ce_q <= CE_DIS;
          addr_q <= '0;
          if (gnt_q == PORT_DBG) begin
            dbg_ack_q <= 1'b1;
            dbg_rdata_q <= bus.rom_inst;
          end else if (!bus.if_flush) begin
            if_ack_q <= 1'b1;
            if_rdata_q <= bus.rom_inst;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef ROM_ARB_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  assign conflict_cnt = cnt_q;
  always_comb cnt_d = (state_q == IDLE && pick_valid && bus.if_req && bus.dbg_req && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  // counts contested grants, saturating at all-ones
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`endif
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized checks of rom_arbiter against a cycle-schedule reference model
module tb_rom_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  logic [DW-1:0] rom [0:255];
  assign b0.rom_inst = rom[b0.rom_addr[9:2]];
  assign b1.rom_inst = rom[b1.rom_addr[9:2]];
`ifdef ROM_ARB_PERF_EN
  logic [31:0] cnt0, cnt1;
`endif
  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
`ifdef ROM_ARB_PERF_EN
    , .conflict_cnt(cnt0)
`endif
  );
  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
`ifdef ROM_ARB_PERF_EN
    , .conflict_cnt(cnt1)
`endif
  );
  int total = 0;
  int bad = 0;

  task automatic reset_all();
    {b0.if_req, b0.if_flush, b0.dbg_req, b1.if_req, b1.if_flush, b1.dbg_req} = '0;
    {b0.if_addr, b0.dbg_addr, b1.if_addr, b1.dbg_addr} = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    b0.if_req = 1'b1;
    b0.dbg_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b0.busy); end
    total++; if (b0.rom_ce !== 1'b0 || b0.rom_addr !== '0) begin bad++; $display("FAIL reset_rom got ce=%b addr=%h exp 0/0", b0.rom_ce, b0.rom_addr); end
    total++; if (b0.if_ack !== 1'b0 || b0.dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got if=%b dbg=%b exp 0/0", b0.if_ack, b0.dbg_ack); end
    total++; if (b0.if_rdata !== '0 || b0.dbg_rdata !== '0) begin bad++; $display("FAIL reset_rdata got if=%h dbg=%h exp 0/0", b0.if_rdata, b0.dbg_rdata); end
    total++; if (b1.busy !== 1'b0 || b1.rom_ce !== 1'b0) begin bad++; $display("FAIL reset_dut1 got busy=%b ce=%b exp 0/0", b1.busy, b1.rom_ce); end
  endtask

  task automatic test_single_if();
    reset_all();
    b0.if_req = 1'b1;
    b0.if_addr = 32'h4;
    @(negedge clk);
    total++; if (b0.rom_ce !== 1'b1 || b0.rom_addr !== 32'h4) begin bad++; $display("FAIL single_acc got ce=%b addr=%h exp 1/4", b0.rom_ce, b0.rom_addr); end
    total++; if (b0.busy !== 1'b1 || b0.if_ack !== 1'b0) begin bad++; $display("FAIL single_busy got busy=%b ack=%b exp 1/0", b0.busy, b0.if_ack); end
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b1 || b0.if_rdata !== 32'h3401_1100) begin bad++; $display("FAIL single_ack got ack=%b rdata=%h exp 1/34011100", b0.if_ack, b0.if_rdata); end
    total++; if (b0.dbg_ack !== 1'b0 || b0.rom_ce !== 1'b0 || b0.rom_addr !== '0) begin bad++; $display("FAIL single_rsp got dbg_ack=%b ce=%b addr=%h exp 0/0/0", b0.dbg_ack, b0.rom_ce, b0.rom_addr); end
    b0.if_req = 1'b0;
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL single_idle got ack=%b busy=%b exp 0/0", b0.if_ack, b0.busy); end
    total++; if (b0.if_rdata !== 32'h3401_1100) begin bad++; $display("FAIL single_hold got=%h exp=34011100", b0.if_rdata); end
  endtask

  task automatic test_tie_rr();
    reset_all();
    {b0.if_req, b0.dbg_req} = 2'b11;
    b0.if_addr = 32'h8;
    b0.dbg_addr = 32'hC;
    @(negedge clk);
    total++; if (b0.rom_addr !== 32'h8) begin bad++; $display("FAIL tie_first_addr got=%h exp=8", b0.rom_addr); end
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b1 || b0.dbg_ack !== 1'b0 || b0.if_rdata !== rom[2]) begin bad++; $display("FAIL tie_first got if=%b dbg=%b rdata=%h exp 1/0/%h", b0.if_ack, b0.dbg_ack, b0.if_rdata, rom[2]); end
    b0.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.rom_ce !== 1'b1 || b0.rom_addr !== 32'hC) begin bad++; $display("FAIL tie_dbg_acc got ce=%b addr=%h exp 1/c", b0.rom_ce, b0.rom_addr); end
    @(negedge clk);
    total++; if (b0.dbg_ack !== 1'b1 || b0.if_ack !== 1'b0 || b0.dbg_rdata !== rom[3]) begin bad++; $display("FAIL tie_dbg got dbg=%b if=%b rdata=%h exp 1/0/%h", b0.dbg_ack, b0.if_ack, b0.dbg_rdata, rom[3]); end
    b0.if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b1 || b0.dbg_ack !== 1'b0) begin bad++; $display("FAIL tie_second got if=%b dbg=%b exp 1/0", b0.if_ack, b0.dbg_ack); end
    {b0.if_req, b0.dbg_req} = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int k;
    reset_all();
    {b1.if_req, b1.dbg_req} = 2'b11;
    b1.if_addr = 32'h10;
    b1.dbg_addr = 32'h14;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++; if (b1.if_ack !== (c % 3 == 2) || b1.dbg_ack !== 1'b0) begin bad++; $display("FAIL fixed_c%0d got if=%b dbg=%b exp %b/0", c, b1.if_ack, b1.dbg_ack, c % 3 == 2); end
    end
    total++; if (b1.if_rdata !== rom[4]) begin bad++; $display("FAIL fixed_rdata got=%h exp=%h", b1.if_rdata, rom[4]); end
    b1.if_req = 1'b0;
    k = 0;
    while (k < 10 && b1.dbg_ack !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 3 || b1.dbg_rdata !== rom[5]) begin bad++; $display("FAIL fixed_dbg got wait=%0d rdata=%h exp 3/%h", k, b1.dbg_rdata, rom[5]); end
    b1.dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [DW-1:0] old;
    reset_all();
    b0.if_req = 1'b1;
    b0.if_addr = 32'h18;
    b0.if_flush = 1'b1;
    @(negedge clk);
    total++; if (b0.busy !== 1'b0 || b0.rom_ce !== 1'b0) begin bad++; $display("FAIL flush_idle got busy=%b ce=%b exp 0/0", b0.busy, b0.rom_ce); end
    b0.if_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b1 || b0.if_rdata !== rom[6]) begin bad++; $display("FAIL flush_prior got ack=%b rdata=%h exp 1/%h", b0.if_ack, b0.if_rdata, rom[6]); end
    old = b0.if_rdata;
    b0.if_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.rom_addr !== 32'h20) begin bad++; $display("FAIL flush_acc got=%h exp=20", b0.rom_addr); end
    b0.if_flush = 1'b1;
    b0.if_req = 1'b0;
    @(negedge clk);
    b0.if_flush = 1'b0;
    total++; if (b0.if_ack !== 1'b0 || b0.if_rdata !== old || b0.busy !== 1'b1) begin bad++; $display("FAIL flush_rsp got ack=%b rdata=%h busy=%b exp 0/%h/1", b0.if_ack, b0.if_rdata, b0.busy, old); end
    @(negedge clk);
    total++; if (b0.busy !== 1'b0 || b0.if_ack !== 1'b0) begin bad++; $display("FAIL flush_done got busy=%b ack=%b exp 0/0", b0.busy, b0.if_ack); end
  endtask

  task automatic test_reset_mid();
    reset_all();
    b0.if_req = 1'b1;
    b0.if_addr = 32'h4;
    @(negedge clk);
    @(negedge clk);
    b0.if_addr = 32'h1C;
    @(negedge clk);
    @(negedge clk);
    total++; if (b0.rom_ce !== 1'b1 || b0.rom_addr !== 32'h1C) begin bad++; $display("FAIL mid_acc got ce=%b addr=%h exp 1/1c", b0.rom_ce, b0.rom_addr); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (b0.busy !== 1'b0 || b0.rom_ce !== 1'b0 || b0.rom_addr !== '0 || b0.if_ack !== 1'b0 || b0.dbg_ack !== 1'b0) begin bad++; $display("FAIL mid_ctrl got busy=%b ce=%b addr=%h ack=%b/%b exp all 0", b0.busy, b0.rom_ce, b0.rom_addr, b0.if_ack, b0.dbg_ack); end
    total++; if (b0.if_rdata !== '0 || b0.dbg_rdata !== '0) begin bad++; $display("FAIL mid_rdata got if=%h dbg=%h exp 0/0", b0.if_rdata, b0.dbg_rdata); end
    rst = 1'b0;
    b0.if_addr = 32'h0;
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b0 || b0.rom_ce !== 1'b1 || b0.rom_addr !== 32'h0) begin bad++; $display("FAIL mid_restart got ack=%b ce=%b addr=%h exp 0/1/0", b0.if_ack, b0.rom_ce, b0.rom_addr); end
    @(negedge clk);
    total++; if (b0.if_ack !== 1'b1 || b0.if_rdata !== rom[0]) begin bad++; $display("FAIL mid_done got ack=%b rdata=%h exp 1/%h", b0.if_ack, b0.if_rdata, rom[0]); end
    b0.if_req = 1'b0;
    @(negedge clk);
  endtask

  // model: a grant in an idle cycle g puts ROM access at g+1, ack at g+2, next idle at g+3
  task automatic test_random();
    int g_c = -10;
    int next_free = 0;
    bit g_port = 1'b0;
    bit last = 1'b1;
    bit ir = 1'b0;
    bit dr = 1'b0;
    bit e_ia, e_da, e_busy, e_ce;
    logic [AW-1:0] g_addr = '0;
    logic [AW-1:0] ia = '0;
    logic [AW-1:0] da = '0;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_ird = '0;
    logic [DW-1:0] e_drd = '0;
    reset_all();
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      e_busy = c == g_c + 1 || c == g_c + 2;
      e_ce = c == g_c + 1;
      e_addr = e_ce ? g_addr : '0;
      e_ia = c == g_c + 2 && g_port == 1'b0;
      e_da = c == g_c + 2 && g_port == 1'b1;
      if (e_ia) e_ird = rom[g_addr[9:2]];
      if (e_da) e_drd = rom[g_addr[9:2]];
      total++; if (b0.busy !== e_busy || b0.rom_ce !== e_ce || b0.rom_addr !== e_addr) begin bad++; $display("FAIL rand_rom c%0d got busy=%b ce=%b addr=%h exp %b/%b/%h", c, b0.busy, b0.rom_ce, b0.rom_addr, e_busy, e_ce, e_addr); end
      total++; if (b0.if_ack !== e_ia || b0.dbg_ack !== e_da) begin bad++; $display("FAIL rand_ack c%0d got if=%b dbg=%b exp %b/%b", c, b0.if_ack, b0.dbg_ack, e_ia, e_da); end
      total++; if (b0.if_rdata !== e_ird || b0.dbg_rdata !== e_drd) begin bad++; $display("FAIL rand_rdata c%0d got if=%h dbg=%h exp %h/%h", c, b0.if_rdata, b0.dbg_rdata, e_ird, e_drd); end
      if (e_ia) ir = 1'b0;
      else if (!ir && $urandom_range(0, 2) == 0) begin ir = 1'b1; ia = $urandom() & 32'hFFFF_FFFC; end
      if (e_da) dr = 1'b0;
      else if (!dr && $urandom_range(0, 2) == 0) begin dr = 1'b1; da = $urandom() & 32'hFFFF_FFFC; end
      b0.if_req = ir;
      b0.if_addr = ia;
      b0.dbg_req = dr;
      b0.dbg_addr = da;
      if (c >= next_free && (ir || dr)) begin
        g_port = (ir && dr) ? ~last : !ir;
        g_addr = g_port ? da : ia;
        last = g_port;
        g_c = c;
        next_free = c + 3;
      end
    end
  endtask

`ifdef ROM_ARB_PERF_EN
  task automatic test_perf();
    reset_all();
    {b0.if_req, b0.dbg_req} = 2'b11;
    b0.if_addr = 32'h8;
    b0.dbg_addr = 32'hC;
    repeat (14) @(negedge clk);
    {b0.if_req, b0.dbg_req} = 2'b00;
    @(negedge clk);
    total++; if (cnt0 !== 32'd5) begin bad++; $display("FAIL perf_count got=%0d exp=5", cnt0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (cnt0 !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d exp=0", cnt0); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom();
    rom[1] = 32'h3401_1100;
    test_reset();
    test_single_if();
    test_tie_rr();
    test_fixed_prio();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef ROM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
